// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the PC and instruction-memory request,
// fills the IF/ID register, buffers a word returned under stall, redirects on branches.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_out,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        misalign,
    output logic        imem_timeout
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned WAIT_W = 8;
    localparam logic [XLEN-1:0]   PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0]   ALIGN_MSK = ~XLEN'(3);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              armed;
    logic [XLEN-1:0]   pc_next;
    logic [XLEN-1:0]   pc_inc;
    logic              ifid_valid_next;
    logic [XLEN-1:0]   ifid_instr_next;
    logic [XLEN-1:0]   ifid_pc_next;
    logic [XLEN-1:0]   buf_instr;
    logic [XLEN-1:0]   buf_instr_next;
    logic [XLEN-1:0]   buf_pc;
    logic [XLEN-1:0]   buf_pc_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              misalign_next;
    logic              timeout_next;
    logic              br_accept;

    assign imem_addr = pc_out;
    assign pc_inc    = pc_out + PC_STEP;
    assign br_accept = branch_taken && (state != IDLE);

    // Next-state and datapath decode; branch redirect outranks stall and memory return.
    always_comb begin
        state_next      = state;
        pc_next         = pc_out;
        ifid_valid_next = ifid_valid;
        ifid_instr_next = ifid_instr;
        ifid_pc_next    = ifid_pc;
        buf_instr_next  = buf_instr;
        buf_pc_next     = buf_pc;
        wait_next       = wait_cnt;
        misalign_next   = 1'b0;
        timeout_next    = imem_timeout || (wait_cnt >= WAIT_LIM);

        if (br_accept) begin
            state_next      = FETCH;
            pc_next         = branch_target & ALIGN_MSK;
            ifid_valid_next = 1'b0;
            buf_instr_next  = '0;
            buf_pc_next     = '0;
            wait_next       = '0;
            misalign_next   = |branch_target[1:0];
        end else begin
            case (state)
                IDLE: begin
                    if (armed) begin
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ready) begin
                        wait_next = '0;
                        if (!stall) begin
                            ifid_valid_next = 1'b1;
                            ifid_instr_next = imem_rdata;
                            ifid_pc_next    = pc_out;
                            pc_next         = pc_inc;
                        end else begin
                            buf_instr_next = imem_rdata;
                            buf_pc_next    = pc_out;
                            state_next     = HOLD;
                        end
                    end else begin
                        if (wait_cnt != WAIT_MAX) begin
                            wait_next = wait_cnt + WAIT_W'(1);
                        end
                        if (!stall) begin
                            ifid_valid_next = 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_valid_next = 1'b1;
                        ifid_instr_next = buf_instr;
                        ifid_pc_next    = buf_pc;
                        pc_next         = pc_inc;
                        state_next      = FETCH;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register; armed keeps IDLE for one full cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            armed    <= 1'b0;
            imem_req <= 1'b0;
        end else begin
            state    <= state_next;
            armed    <= 1'b1;
            imem_req <= (state_next == FETCH);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out       <= RESET_PC & ALIGN_MSK;
            ifid_valid   <= 1'b0;
            ifid_instr   <= '0;
            ifid_pc      <= '0;
            buf_instr    <= '0;
            buf_pc       <= '0;
            wait_cnt     <= '0;
            misalign     <= 1'b0;
            imem_timeout <= 1'b0;
        end else begin
            pc_out       <= pc_next;
            ifid_valid   <= ifid_valid_next;
            ifid_instr   <= ifid_instr_next;
            ifid_pc      <= ifid_pc_next;
            buf_instr    <= buf_instr_next;
            buf_pc       <= buf_pc_next;
            wait_cnt     <= wait_next;
            misalign     <= misalign_next;
            imem_timeout <= timeout_next;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_ctrl;

    localparam int unsigned TO = 16;
    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_out;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        misalign;
    logic        imem_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int          m_mode;
    int          m_since;
    int          m_wait;
    logic [31:0] m_pc, m_instr, m_ifpc, m_hinstr, m_hpc;
    logic        m_valid, m_mis, m_to;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .pc_out(pc_out),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .misalign(misalign), .imem_timeout(imem_timeout)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = M_IDLE; m_since = 0; m_wait = 0;
        m_pc = 32'h0; m_instr = '0; m_ifpc = '0; m_hinstr = '0; m_hpc = '0;
        m_valid = 1'b0; m_mis = 1'b0; m_to = 1'b0;
    endfunction

    // One rising edge of the fetch rules, using the inputs currently driven.
    function automatic void model_step();
        int old_wait;
        old_wait = m_wait;
        m_mis = 1'b0;
        if (m_mode == M_IDLE) begin
            if (m_since >= 1) m_mode = M_FETCH;
        end else if (branch_taken) begin
            m_pc = {branch_target[31:2], 2'b00};
            m_valid = 1'b0; m_hinstr = '0; m_hpc = '0; m_wait = 0;
            m_mis = (branch_target[1:0] != 2'b00);
            m_mode = M_FETCH;
        end else if (m_mode == M_HOLD) begin
            if (!stall) begin
                m_valid = 1'b1; m_instr = m_hinstr; m_ifpc = m_hpc;
                m_pc = m_pc + 32'd4; m_mode = M_FETCH;
            end
        end else if (imem_ready) begin
            m_wait = 0;
            if (!stall) begin
                m_valid = 1'b1; m_instr = imem_rdata; m_ifpc = m_pc; m_pc = m_pc + 32'd4;
            end else begin
                m_hinstr = imem_rdata; m_hpc = m_pc; m_mode = M_HOLD;
            end
        end else begin
            m_wait = (m_wait < 255) ? m_wait + 1 : 255;
            if (!stall) m_valid = 1'b0;
        end
        if (old_wait >= int'(TO)) m_to = 1'b1;
        if (m_since < 1000) m_since++;
    endfunction

    function automatic logic [131:0] dut_vec();
        return {pc_out, imem_addr, imem_req, ifid_valid, ifid_instr, ifid_pc, misalign, imem_timeout};
    endfunction

    function automatic logic [131:0] model_vec();
        logic req;
        req = (m_mode == M_FETCH);
        return {m_pc, m_pc, req, m_valid, m_instr, m_ifpc, m_mis, m_to};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem_ready = 1'b0; imem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        n_checks++;
        if (dut_vec() !== model_vec()) $display("FAIL reset_vec dut=%h exp=%h", dut_vec(), model_vec());
        else n_pass++;
        n_checks++;
        if (pc_out !== 32'h0 || imem_req !== 1'b0) $display("FAIL reset_pc pc=%h req=%b exp pc=0 req=0", pc_out, imem_req);
        else n_pass++;
        do_reset();
        tick();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL reset_req_edge1 got=%b exp=0", imem_req);
        else n_pass++;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || pc_out !== 32'h0) $display("FAIL reset_req_edge2 req=%b pc=%h exp req=1 pc=0", imem_req, pc_out);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
        do_reset();
        imem_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            imem_rdata = m_pc;
            tick();
            n_checks++;
            if (pc_out !== exp_pc[i] || ifid_valid !== (i > 0)) $display("FAIL stream_pc i=%0d pc=%h valid=%b exp pc=%h valid=%b", i, pc_out, ifid_valid, exp_pc[i], i > 0);
            else n_pass++;
            n_checks++;
            if (dut_vec() !== model_vec()) $display("FAIL stream_vec i=%0d dut=%h exp=%h", i, dut_vec(), model_vec());
            else n_pass++;
        end
        n_checks++;
        if (ifid_pc !== 32'h8) $display("FAIL stream_ifid_pc got=%h exp=00000008", ifid_pc);
        else n_pass++;
    endtask

    task automatic test_stall_hold();
        branch_taken = 1'b1; branch_target = 32'h10; imem_ready = 1'b1; stall = 1'b0;
        tick();
        branch_taken = 1'b0;
        stall = 1'b1; imem_rdata = 32'hA5A5_0010;
        tick();
        for (int i = 0; i < 2; i++) begin
            imem_rdata = 32'hDEAD_BEEF;
            n_checks++;
            if (imem_req !== 1'b0 || pc_out !== 32'h10 || ifid_valid !== 1'b0) $display("FAIL hold_wait i=%0d req=%b pc=%h valid=%b exp req=0 pc=10 valid=0", i, imem_req, pc_out, ifid_valid);
            else n_pass++;
            tick();
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (ifid_pc !== 32'h10 || pc_out !== 32'h14 || ifid_instr !== 32'hA5A5_0010 || ifid_valid !== 1'b1) $display("FAIL hold_release ifid_pc=%h pc=%h instr=%h valid=%b exp 10 14 a5a50010 1", ifid_pc, pc_out, ifid_instr, ifid_valid);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== model_vec()) $display("FAIL hold_vec dut=%h exp=%h", dut_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_branch();
        stall = 1'b1; imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
        tick();
        n_checks++;
        if (pc_out !== 32'h20 || ifid_valid !== 1'b0 || misalign !== 1'b0) $display("FAIL branch_aligned pc=%h valid=%b mis=%b exp 20 0 0", pc_out, ifid_valid, misalign);
        else n_pass++;
        branch_target = 32'h23;
        tick();
        n_checks++;
        if (pc_out !== 32'h20 || misalign !== 1'b1) $display("FAIL branch_misalign pc=%h mis=%b exp 20 1", pc_out, misalign);
        else n_pass++;
        branch_taken = 1'b0;
        tick();
        n_checks++;
        if (misalign !== 1'b0) $display("FAIL misalign_pulse got=%b exp=0", misalign);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== model_vec()) $display("FAIL branch_vec dut=%h exp=%h", dut_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        tick();
        tick();
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_checks++;
            if (ifid_valid !== 1'b0 || imem_addr !== 32'h0 || imem_timeout !== 1'b0) $display("FAIL timeout_wait i=%0d valid=%b addr=%h to=%b exp 0 0 0", i, ifid_valid, imem_addr, imem_timeout);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (imem_timeout !== 1'b1) $display("FAIL timeout_set got=%b exp=1", imem_timeout);
        else n_pass++;
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        n_checks++;
        if (imem_timeout !== 1'b1 || ifid_valid !== 1'b1) $display("FAIL timeout_sticky to=%b valid=%b exp 1 1", imem_timeout, ifid_valid);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== model_vec()) $display("FAIL timeout_vec dut=%h exp=%h", dut_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_wrap();
        stall = 1'b0; imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        tick();
        n_checks++;
        if (pc_out !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC) $display("FAIL pc_wrap pc=%h ifid_pc=%h exp 00000000 fffffffc", pc_out, ifid_pc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        stall = 1'b1; imem_ready = 1'b1;
        tick();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL mid_hold_enter req=%b exp=0", imem_req);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== model_vec() || pc_out !== 32'h0) $display("FAIL mid_hold_reset dut=%h exp=%h", dut_vec(), model_vec());
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1; stall = 1'b0;
        tick();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL mid_hold_edge1 req=%b exp=0", imem_req);
        else n_pass++;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || ifid_valid !== 1'b0) $display("FAIL mid_hold_edge2 req=%b valid=%b exp 1 0", imem_req, ifid_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            branch_taken  = ($urandom_range(7) == 0);
            branch_target = $urandom;
            stall         = ($urandom_range(2) == 0);
            imem_ready    = ($urandom_range(2) != 0);
            imem_rdata    = $urandom;
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) $display("FAIL random_vec cyc=%0d dut=%h exp=%h", i, dut_vec(), model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_hold();
        test_branch();
        test_timeout();
        test_wrap();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
